// File: rtl/count_scheduler.sv
// count_scheduler
//   Four (N) independent W-bit counter contexts sharing a single incrementer.
//   Each cycle a round-robin arbiter picks at most one requester. The arbiter
//   searches upward from a rotating pointer, and the granted context
//   increments by one modulo 2^W. Per-context clears always take effect, and
//   a clear beats an increment to the same context. All outputs are
//   registered, so the arbitration of cycle t is visible at cycle t+1.
//
// Ports
//   clock_reset [1:0]  bit 0 = clock, bit 1 = synchronous active-high reset
//   en                 arbitration enable; 0 suppresses all grants
//   req   [N-1:0]      level-sensitive increment requests
//   clr   [N-1:0]      per-context synchronous clear
//   grant [N-1:0]      one-hot grant from the previous arbitration, 0 if none
//   grant_valid        1 when grant is non-zero
//   value [W-1:0]      post-update value of the granted context, 0 if no grant
//   wrap               granted context rolled over from 2^W-1 to 0
//   counts [N*W-1:0]   all contexts, context k at bits [k*W +: W]
module count_scheduler #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic [1:0]     clock_reset,
  input  logic           en,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   clr,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [W-1:0]   value,
  output logic           wrap,
  output logic [N*W-1:0] counts
);

  localparam int PW = $clog2(N);

  logic clk;
  logic rst;
  assign clk = clock_reset[0];
  assign rst = clock_reset[1];

  // Declaration initialisers make the power-up state match the reset state.
  logic [N-1:0][W-1:0] ctx         = '0;
  logic [PW-1:0]       ptr         = '0;
  logic [N-1:0]        grant_q     = '0;
  logic                grant_vld_q = 1'b0;
  logic [W-1:0]        value_q     = '0;
  logic                wrap_q      = 1'b0;

  // Round-robin search: the first set request at or after ptr. The index
  // arithmetic wraps naturally because N is a power of two.
  logic          hit;
  logic [PW-1:0] sel;
  logic [PW-1:0] cand;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves it unassigned and no latch is inferred.
    hit  = 1'b0;
    sel  = ptr;
    cand = ptr;
    for (int i = 0; i < N; i++) begin
      cand = ptr + PW'(i);
      if (en && !hit && req[cand]) begin
        hit = 1'b1;
        sel = cand;
      end
    end
  end

  // Shared incrementer. Clears are applied last so that a clear overrides
  // an increment to the same context.
  logic [W-1:0]        inc;
  logic [N-1:0][W-1:0] ctx_nxt;

  assign inc = ctx[sel] + W'(1);

  always_comb begin
    ctx_nxt = ctx;
    if (hit) ctx_nxt[sel] = inc;
    for (int k = 0; k < N; k++) begin
      if (clr[k]) ctx_nxt[k] = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values no matter what order the statements are in.
    if (rst) begin
      // NOTE: the contexts are a handful of flops, not a RAM macro, so
      // clearing them on reset costs nothing and is required behaviour.
      ctx         <= '0;
      ptr         <= '0;
      grant_q     <= '0;
      grant_vld_q <= 1'b0;
      value_q     <= '0;
      wrap_q      <= 1'b0;
    end else begin
      ctx         <= ctx_nxt;
      grant_vld_q <= hit;
      grant_q     <= hit ? (N'(1) << sel) : '0;
      // ctx_nxt already carries clear-wins, so a cleared grant reports 0.
      value_q     <= hit ? ctx_nxt[sel] : '0;
      wrap_q      <= hit && !clr[sel] && (&ctx[sel]);
      if (hit) ptr <= sel + PW'(1);
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_vld_q;
  assign value       = value_q;
  assign wrap        = wrap_q;
  assign counts      = ctx;

endmodule
